regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between several writeback requesters, e.g. the ALU result path and the load unit.
- Arbitrates round-robin and registers the winning write into a one-cycle output stage that drives the register file write port.
- Keeps a busy-bit scoreboard of registers with a write in flight, so the issue logic can detect read-after-write hazards.
- Sits between the execute/load units and the 8x8-bit register file.

---
 rtl/tiny_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tiny_pkg.sv
// Shared constants and types for the register-file writeback path.
package tiny_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam logic [ADDR_W-1:0] ZERO_REG = 3'd0;

    // One writeback request: destination register and the value to write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, searching upward from
// the pointer with wrap-around. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               stall_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    int   idx;
    logic found;

    // Grant the first requester at or after the pointer; stall blocks all grants.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && !stall_i && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between writeback requesters with a
// round-robin arbiter, a one-cycle registered write stage, and a busy-bit
// scoreboard for read-after-write hazard detection.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wb_stall,
    output logic                      rf_write_en,
    output logic [ADDR_W-1:0]         rf_addr_wr,
    output logic [DATA_W-1:0]         rf_data_wr,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic [ADDR_W-1:0]         chk_addr1,
    input  logic [ADDR_W-1:0]         chk_addr2,
    output logic                      chk_busy1,
    output logic                      chk_busy2
);

    import tiny_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;
    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREGS-1:0]  busy_q, busy_d;

    logic [NUM_REQ-1:0] gnt;
    logic               xfer;
    int                 gidx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // Reset also blocks grants, so ready is low while rst is asserted.
    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .stall_i (wb_stall | ~rst),
        .gnt_o   (gnt)
    );

    assign req_ready  = gnt;
    assign xfer       = |(gnt & req_valid);
    assign rf_write_en = wen_q;
    assign rf_addr_wr = waddr_q;
    assign rf_data_wr = wdata_q;
    assign chk_busy1  = busy_q[chk_addr1];
    assign chk_busy2  = busy_q[chk_addr2];

    // Select the winning request's address and data from the flattened buses.
    always_comb begin
        gidx     = 0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gidx     = i;
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state: pointer advances past the winner, output stage loads the
    // winner (writes to the zero register are suppressed), busy bits track
    // reservations and commits with reservation taking precedence.
    always_comb begin
        ptr_d   = ptr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        if (xfer) begin
            ptr_d   = (gidx == NUM_REQ - 1) ? '0 : PTR_W'(gidx + 1);
            wen_d   = (sel_addr != ADDR_W'(ZERO_REG));
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end
        if (wen_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any in-flight write and clears the scoreboard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model of the
// arbiter pointer and busy bits plus a scoreboard of expected writes.
module tb_regfile_wb_arbiter;

    import tiny_pkg::*;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*3-1:0]   req_addr;
    logic [N*8-1:0]   req_data;
    logic             wb_stall;
    logic             rf_write_en;
    logic [2:0]       rf_addr_wr;
    logic [7:0]       rf_data_wr;
    logic             rsv_valid;
    logic [2:0]       rsv_addr;
    logic [2:0]       chk_addr1, chk_addr2;
    logic             chk_busy1, chk_busy2;

    int n_tests = 0;
    int n_fail  = 0;

    wb_req_t    sb[$];
    int         m_ptr = 0;
    logic [7:0] m_busy = '0;
    logic [N-1:0] last_ready = '0;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(8), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .wb_stall    (wb_stall),
        .rf_write_en (rf_write_en),
        .rf_addr_wr  (rf_addr_wr),
        .rf_data_wr  (rf_data_wr),
        .rsv_valid   (rsv_valid),
        .rsv_addr    (rsv_addr),
        .chk_addr1   (chk_addr1),
        .chk_addr2   (chk_addr2),
        .chk_busy1   (chk_busy1),
        .chk_busy2   (chk_busy2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: compare DUT against the model, then advance the
    // model by the edge that is about to happen.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic         found;
        int           idx, gi;
        logic         cur_wen;
        wb_req_t      cur, nxt;
        logic [7:0]   nb;
        logic         legal;

        if (!rst) begin
            m_ptr  = 0;
            m_busy = '0;
            sb.delete();
            check_val("rst_addr", 32'(rf_addr_wr), 32'h0);
            check_val("rst_data", 32'(rf_data_wr), 32'h0);
        end

        cur_wen = 1'b0;
        cur     = '0;
        if (sb.size() > 0) begin
            cur     = sb.pop_front();
            cur_wen = 1'b1;
            check_val("wr_addr", 32'(rf_addr_wr), 32'(cur.addr));
            check_val("wr_data", 32'(rf_data_wr), 32'(cur.data));
        end
        check_val("wr_en", 32'(rf_write_en), 32'(cur_wen));

        exp_rdy = '0;
        found   = 1'b0;
        gi      = 0;
        if (rst && !wb_stall) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req_valid[idx]) begin
                    exp_rdy[idx] = 1'b1;
                    found        = 1'b1;
                    gi           = idx;
                end
            end
        end
        check_val("ready", 32'(req_ready), 32'(exp_rdy));
        check_val("busy1", 32'(chk_busy1), 32'(m_busy[chk_addr1]));
        check_val("busy2", 32'(chk_busy2), 32'(m_busy[chk_addr2]));
        last_ready = req_ready;

        if (rst) begin
            if (found) begin
                m_ptr = (gi + 1) % N;
                nxt.addr = req_addr[gi*3 +: 3];
                nxt.data = req_data[gi*8 +: 8];
                if (nxt.addr != 3'd0) sb.push_back(nxt);
            end
            nb = m_busy;
            if (cur_wen) nb[cur.addr] = 1'b0;
            if (rsv_valid && rsv_addr != 3'd0) begin
                legal = !m_busy[rsv_addr] || (cur_wen && cur.addr == rsv_addr);
                check_val("rsv_legal", 32'(legal), 32'h1);
                nb[rsv_addr] = 1'b1;
            end
            m_busy = nb;
        end
    end

    initial begin
        rst = 1'b0; wb_stall = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
        chk_addr1 = 3'd5; chk_addr2 = 3'd1;
        req_valid = 2'b11; req_addr = {3'd2, 3'd1}; req_data = {8'h22, 8'h11};
        repeat (2) step();
        // Release reset with both requesters valid: alternating grants.
        rst = 1'b1;
        repeat (4) step();
        req_valid = 2'b00; step();

        // Single write from requester 1.
        req_valid = 2'b10; req_addr[5:3] = 3'd3; req_data[15:8] = 8'h55; step();
        req_valid = 2'b00; repeat (2) step();

        // Stall with both valid, then release.
        req_valid = 2'b11; req_addr = {3'd2, 3'd1}; wb_stall = 1'b1;
        repeat (3) step();
        wb_stall = 1'b0; repeat (2) step();
        req_valid = 2'b00; step();

        // Scoreboard: reserve, commit, clear.
        rsv_valid = 1'b1; rsv_addr = 3'd5; step();
        rsv_valid = 1'b0; step();
        req_valid = 2'b01; req_addr[2:0] = 3'd5; req_data[7:0] = 8'hA5; step();
        req_valid = 2'b00; repeat (2) step();
        // Reserve again, then reserve on the commit edge: stays busy.
        rsv_valid = 1'b1; rsv_addr = 3'd5; step();
        rsv_valid = 1'b0;
        req_valid = 2'b01; req_data[7:0] = 8'h5A; step();
        req_valid = 2'b00; rsv_valid = 1'b1; rsv_addr = 3'd5; step();
        rsv_valid = 1'b0; repeat (2) step();
        req_valid = 2'b01; req_data[7:0] = 8'h3C; step();
        req_valid = 2'b00; repeat (2) step();

        // Zero register: granted, advances pointer, no write, never busy.
        chk_addr1 = 3'd0; chk_addr2 = 3'd5;
        req_valid = 2'b01; req_addr[2:0] = 3'd0; req_data[7:0] = 8'hFF; step();
        req_valid = 2'b00; rsv_valid = 1'b1; rsv_addr = 3'd0; step();
        rsv_valid = 1'b0; step();
        req_valid = 2'b11; req_addr = {3'd6, 3'd7}; step();
        req_valid = 2'b00; step();

        // Reset during an in-flight write with a reserved register.
        chk_addr1 = 3'd4;
        rsv_valid = 1'b1; rsv_addr = 3'd4; step();
        rsv_valid = 1'b0;
        req_valid = 2'b01; req_addr[2:0] = 3'd4; req_data[7:0] = 8'h44; step();
        req_valid = 2'b00; rst = 1'b0; step();
        rst = 1'b1; repeat (2) step();

        // Random traffic honouring the hold-while-waiting obligation.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !last_ready[i])) begin
                    req_valid[i]       = ($urandom_range(0, 3) != 0);
                    req_addr[i*3 +: 3] = 3'($urandom_range(0, 7));
                    req_data[i*8 +: 8] = 8'($urandom_range(0, 255));
                end
            end
            wb_stall  = ($urandom_range(0, 5) == 0);
            rsv_addr  = 3'($urandom_range(1, 7));
            rsv_valid = ($urandom_range(0, 2) == 0) && !m_busy[rsv_addr];
            chk_addr1 = 3'($urandom_range(0, 7));
            chk_addr2 = 3'($urandom_range(0, 7));
            step();
        end
        req_valid = 2'b00; rsv_valid = 1'b0; wb_stall = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
